fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter / instruction address width.
REQ-002 SHALL have parameter TGT_W, default 5, meaning branch target LUT index width (32 entries).
REQ-003 SHALL have parameter PROG_LEN, default 1024, meaning program length in instructions; the last address is PROG_LEN-1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold current PC this cycle.
REQ-007 SHALL have port halt  input  1  instruction at pc is a halt.
REQ-008 SHALL have port branch  input  1  instruction at pc is a conditional branch.
REQ-009 SHALL have port taken  input  1  branch condition true (ALU flag).
REQ-010 SHALL have port rel  input  1  1 = PC-relative target, 0 = absolute target.
REQ-011 SHALL have port tgt_idx  input  TGT_W  branch LUT index.
REQ-012 SHALL have port pc  output  PC_W  instruction memory address.
REQ-013 SHALL have port fetch_valid  output  1  pc holds a live fetch address this cycle.
REQ-014 SHALL have port done  output  1  program finished; sticky until reset.
REQ-015 SHALL have port instr_count  output  16  count of retired (non-stalled) instructions.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; IDLE always moves to RUN on the next edge (one bubble after reset release).
REQ-017 SHALL drive fetch_valid=1 only in RUN, and done=1 only in HALT.
REQ-018 SHALL apply RUN-state priority per cycle: halt > stall > (branch & taken) > sequential increment.
REQ-019 SHALL, on halt in RUN, move to HALT with pc unchanged; instr_count increments by 1 (the halt retires).
REQ-020 SHALL, on stall (no halt), hold pc, state and instr_count.
REQ-021 SHALL, on branch & taken, load pc with LUT[tgt_idx] when rel=0, or with pc + signed(LUT[tgt_idx]) modulo 2^PC_W when rel=1.
REQ-022 SHALL, on branch & !taken or a non-branch, load pc+1.
REQ-023 SHALL, when pc==PROG_LEN-1 and a sequential increment would occur, enter HALT with pc unchanged instead of wrapping.
REQ-024 SHALL allow taken branches to any address, including backward targets and PC-relative wrap modulo 2^PC_W; no bounds check applies.
REQ-025 SHALL increment instr_count once per RUN cycle without stall, saturating at 16'hFFFF.
REQ-026 SHALL, in HALT, ignore all inputs and hold pc, done and instr_count until reset.
REQ-027 SHALL ignore taken when branch=0, and ignore rel and tgt_idx unless branch & taken.

Reset
REQ-028 SHALL, on reset assertion at any time (including mid-RUN or HALT), immediately set state=IDLE, pc=0, fetch_valid=0, done=0, instr_count=0.
REQ-029 SHALL hold all outputs at their reset values while reset is high.

Structure
REQ-030 SHALL take PC_W/TGT_W defaults, the state enum type and the 32-entry branch target constant array from shared package x9_fetch_pkg.
REQ-031 SHALL instantiate one combinational sub-module, branch_lut, mapping tgt_idx to a PC_W-bit target read from the package array.
REQ-032 SHALL register pc, state, done and instr_count only; next-PC selection is combinational.

Verification
REQ-033 SHALL cover: reset pulse, no branches or halt -> one IDLE cycle, then pc = 0,1,2,... with fetch_valid=1; after 1024 RUN cycles, done=1 with pc=1023 and instr_count=1024.
REQ-034 SHALL cover: LUT[3]=10'd40, at pc=5 branch=1 taken=1 rel=0 tgt_idx=3 -> next pc=40; with taken=0 -> next pc=6.
REQ-035 SHALL cover: LUT[7]=10'h3FC (-4), at pc=2 branch=1 taken=1 rel=1 tgt_idx=7 -> next pc=1022 (wrap).
REQ-036 SHALL cover: stall held 3 cycles at pc=8 -> pc stays 8 and instr_count is unchanged; simultaneous stall and halt -> HALT entered, done=1.
REQ-037 SHALL cover: halt at pc=12 -> done=1 next cycle, pc=12, later inputs ignored; reset asserted mid-RUN at pc=20 -> pc=0 and done=0 immediately (asynchronous).

Source files
------------

// File: rtl/x9_fetch_pkg.sv
// Shared fetch-unit types, default widths and the branch target table.
package x9_fetch_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int TGT_W_DEF = 5;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic halt;
    logic stall;
    logic branch;
    logic taken;
    logic rel;
  } fetch_ctl_t;

  // Entries are absolute addresses or two's-complement PC offsets, depending on rel.
  localparam logic [PC_W_DEF-1:0] BR_TGT [LUT_DEPTH] = '{
    10'd0,   10'd1,   10'd16,  10'd40,  10'd100, 10'd200, 10'd512, 10'h3FC,
    10'h3FF, 10'd2,   10'd8,   10'h3F0, 10'd1000, 10'd1023, 10'h200, 10'd64,
    10'd300, 10'h380, 10'd12,  10'd20,  10'd700, 10'h3E0, 10'd5,   10'd900,
    10'h300, 10'd3,   10'd128, 10'h3F8, 10'd1020, 10'd256, 10'd33,  10'h3FE
  };

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target lookup; entries are sign-extended to PC_W.
module branch_lut
  import x9_fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int TGT_W = TGT_W_DEF
) (
  input  logic [TGT_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  tgt
);

  logic [LUT_IDX_W-1:0] idx;

  always_comb begin
    idx = LUT_IDX_W'(tgt_idx);
    tgt = PC_W'($signed(BR_TGT[idx]));
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE bubble, RUN with branch/stall/halt, sticky HALT.
module fetch_unit
  import x9_fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int TGT_W    = TGT_W_DEF,
  parameter int PROG_LEN = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic             taken,
  input  logic             rel,
  input  logic [TGT_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic [15:0]      instr_count
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic [15:0]     cnt_q, cnt_d;

  fetch_ctl_t      ctl;
  logic [PC_W-1:0] lut_tgt;
  logic [PC_W-1:0] br_tgt;

  branch_lut #(
    .PC_W  (PC_W),
    .TGT_W (TGT_W)
  ) u_lut (
    .tgt_idx (tgt_idx),
    .tgt     (lut_tgt)
  );

  always_comb begin
    ctl = '{halt: halt, stall: stall, branch: branch, taken: taken, rel: rel};
    // Relative targets wrap naturally at 2^PC_W; no bounds check on branches.
    br_tgt = ctl.rel ? (pc_q + lut_tgt) : lut_tgt;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (ctl.halt) begin
          state_d = HALT;
          done_d  = 1'b1;
          cnt_d   = sat_inc16(cnt_q);
        end else if (!ctl.stall) begin
          cnt_d = sat_inc16(cnt_q);
          if (ctl.branch && ctl.taken) begin
            pc_d = br_tgt;
          end else if (pc_q == LAST_PC) begin
            // Falling off the end of the program halts instead of wrapping.
            state_d = HALT;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against a behavioural model.
module tb_fetch_unit;

  localparam int PC_W     = 10;
  localparam int TGT_W    = 5;
  localparam int PROG_LEN = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0, halt = 1'b0, branch = 1'b0, taken = 1'b0, rel = 1'b0;
  logic [TGT_W-1:0] tgt_idx = '0;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid, done;
  logic [15:0]      instr_count;

  fetch_unit #(.PC_W(PC_W), .TGT_W(TGT_W), .PROG_LEN(PROG_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt        (halt),
    .branch      (branch),
    .taken       (taken),
    .rel         (rel),
    .tgt_idx     (tgt_idx),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int lut[32] = '{
    0, 1, 16, 40, 100, 200, 512, 1020,
    1023, 2, 8, 1008, 1000, 1023, 512, 64,
    300, 896, 12, 20, 700, 992, 5, 900,
    768, 3, 128, 1016, 1020, 256, 33, 1022
  };

  // Model: phase 0 = waiting for first fetch, 1 = fetching, 2 = finished.
  int m_phase, m_pc, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},   32'(pc),          32'(m_pc));
    chk({tag, ".fv"},   32'(fetch_valid), 32'(m_phase == 1));
    chk({tag, ".done"}, 32'(done),        32'(m_phase == 2));
    chk({tag, ".cnt"},  32'(instr_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (halt) begin
        if (m_cnt < 65535) m_cnt++;
        m_phase = 2;
      end else if (!stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (branch && taken) begin
          int s;
          s = lut[tgt_idx];
          if (rel) begin
            if (s >= 512) s -= 1024;
            m_pc = ((m_pc + s) % 1024 + 1024) % 1024;
          end else begin
            m_pc = s;
          end
        end else if (m_pc == PROG_LEN - 1) begin
          m_phase = 2;
        end else begin
          m_pc++;
        end
      end
    end
  endtask

  task automatic set_in(input logic h, input logic s, input logic b, input logic t,
                        input logic r, input logic [TGT_W-1:0] idx);
    halt = h; stall = s; branch = b; taken = t; rel = r; tgt_idx = idx;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, '0);
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b0;
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    set_in(0, 0, 0, 0, 0, '0);
    while (!(m_phase == 1 && m_pc == target) && n < 2000) begin
      cycle("run_to");
      n++;
    end
    if (n >= 2000) chk("run_to_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    model_reset();
    check_all("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Straight-line program runs to the last address and halts there.
    for (int i = 0; i < PROG_LEN + 1; i++) cycle("seq");
    chk("seq_end.done", 32'(done), 32'd1);
    chk("seq_end.pc",   32'(pc), 32'd1023);
    chk("seq_end.cnt",  32'(instr_count), 32'd1024);
    cycle("seq_halted");

    apply_reset();
    run_to(5);
    set_in(0, 0, 1, 1, 0, 5'd3);
    cycle("br_abs");
    chk("br_abs.pc40", 32'(pc), 32'd40);

    apply_reset();
    run_to(5);
    set_in(0, 0, 1, 0, 0, 5'd3);
    cycle("br_nt");
    chk("br_nt.pc6", 32'(pc), 32'd6);

    apply_reset();
    run_to(2);
    set_in(0, 0, 1, 1, 1, 5'd7);
    cycle("br_rel");
    chk("br_rel.pc1022", 32'(pc), 32'd1022);
    set_in(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle("br_rel_tail");

    apply_reset();
    run_to(8);
    set_in(0, 1, 1, 1, 0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.pc8", 32'(pc), 32'd8);
      chk("stall.cnt8", 32'(instr_count), 32'd8);
    end
    set_in(1, 1, 0, 0, 0, '0);
    cycle("stall_halt");
    chk("stall_halt.done", 32'(done), 32'd1);
    chk("stall_halt.cnt9", 32'(instr_count), 32'd9);

    apply_reset();
    run_to(12);
    set_in(1, 0, 0, 0, 0, '0);
    cycle("halt12");
    chk("halt12.done", 32'(done), 32'd1);
    chk("halt12.pc", 32'(pc), 32'd12);
    for (int i = 0; i < 8; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom));
      cycle("halt_ignore");
    end

    apply_reset();
    run_to(20);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst.pc", 32'(pc), 32'd0);
    chk("mid_rst.done", 32'(done), 32'd0);
    chk("mid_rst.fv", 32'(fetch_valid), 32'd0);
    chk("mid_rst.cnt", 32'(instr_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      if ((m_phase == 2 && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
        set_in($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 5'($urandom));
        cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
